// File: rtl/seq_divider.sv
// Sequential restoring divider with RV32M DIV/DIVU/REM/REMU semantics.
// One quotient bit per clock; divide-by-zero and signed overflow resolve in one cycle.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   shifted, diff;
  logic             step_bit;
  logic [WIDTH-1:0] step_rem, q_raw;

  // dvd_q doubles as the quotient register: dividend bits shift out as quotient bits shift in.
  always_comb begin
    dvd_neg  = is_signed & dividend[WIDTH-1];
    dvs_neg  = is_signed & divisor[WIDTH-1];
    dvd_abs  = dvd_neg ? -dividend : dividend;
    dvs_abs  = dvs_neg ? -divisor : divisor;
    shifted  = {prem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    step_bit = ~diff[WIDTH];
    step_rem = step_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_raw    = {dvd_q[WIDTH-2:0], step_bit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            state_d = StDone;
          end else if (is_signed && dividend == MinNeg && divisor == '1) begin
            quo_d   = dividend;
            rem_d   = '0;
            state_d = StDone;
          end else begin
            dvd_d   = dvd_abs;
            dvs_d   = dvs_abs;
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
            prem_d  = '0;
            cnt_d   = '0;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        prem_d = step_rem;
        dvd_d  = q_raw;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          quo_d   = q_neg_q ? -q_raw : q_raw;
          rem_d   = r_neg_q ? -step_rem : step_rem;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign busy      = (state_q == StBusy);
  assign done      = (state_q == StDone);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases, randomized operands against
// an arithmetic reference model, start-ignore, mid-operation reset and back-to-back timing.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;

  int pass_cnt = 0;
  int total = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
  } vec_t;

  // RV32M results from plain 64-bit arithmetic (truncating division).
  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output bit special);
    longint sa, sb;
    special = 1'b0;
    if (b == 0) begin
      q = '1; r = a; special = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; special = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Drives one operation. poke > 0 raises start at that busy sample; poke < 0 raises start in DONE.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke, output logic [W-1:0] q, output logic [W-1:0] r,
                        output int lat, output int bcnt, output bit overlap,
                        output bit timed_out, output bit after_bad);
    @(negedge clk);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    lat = -1; bcnt = 0; overlap = 0; timed_out = 1; after_bad = 0; q = '0; r = '0;
    for (int cyc = 1; cyc <= int'(W) + 10; cyc++) begin
      @(negedge clk);
      if (busy && done) overlap = 1;
      if (busy) bcnt++;
      if (done) begin
        lat = cyc - 1; q = quotient; r = remainder; timed_out = 0;
        if (poke < 0) start = 1'b1;
        break;
      end
      if (cyc == poke) begin
        start = 1'b1; dividend = $urandom; divisor = $urandom_range(1, 9);
      end else begin
        start = 1'b0;
      end
    end
    if (!timed_out) begin
      @(negedge clk);
      after_bad = done | busy;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({busy, done, quotient, remainder} !== '0) begin
      $display("FAIL reset_state busy=%b done=%b q=%h r=%h, required all zero",
               busy, done, quotient, remainder);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed;
    vec_t v[$];
    logic [W-1:0] q, r, mq, mr;
    int lat, bcnt, elat;
    bit ov, to, ab, sp;
    v.push_back('{1'b0, 32'd100,        32'd7,          32'd14,         32'd2});
    v.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF});
    v.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1});
    v.push_back('{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5});
    v.push_back('{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5});
    v.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0});
    v.push_back('{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000});
    v.push_back('{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0});
    v.push_back('{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0});
    v.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE});
    v.push_back('{1'b0, 32'd3,          32'd10,         32'd0,          32'd3});
    foreach (v[i]) begin
      ref_div(v[i].s, v[i].a, v[i].b, mq, mr, sp);
      elat = sp ? 0 : int'(W);
      run_op(v[i].s, v[i].a, v[i].b, (i == 0) ? -1 : 0, q, r, lat, bcnt, ov, to, ab);
      total++;
      if (to || q !== v[i].eq || r !== v[i].er) begin
        $display("FAIL directed[%0d] q=%h r=%h timeout=%b, required q=%h r=%h",
                 i, q, r, to, v[i].eq, v[i].er);
      end else pass_cnt++;
      total++;
      if (lat != elat || bcnt != elat) begin
        $display("FAIL directed_timing[%0d] latency=%0d busy_cycles=%0d, required %0d/%0d",
                 i, lat, bcnt, elat, elat);
      end else pass_cnt++;
      total++;
      if (ov || ab) begin
        $display("FAIL directed_pulse[%0d] overlap=%b busy_or_done_after=%b, required 0/0",
                 i, ov, ab);
      end else pass_cnt++;
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, q, r, mq, mr;
    logic s;
    int lat, bcnt;
    bit ov, to, ab, sp;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = -$urandom_range(1, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      ref_div(s, a, b, mq, mr, sp);
      run_op(s, a, b, 0, q, r, lat, bcnt, ov, to, ab);
      total++;
      if (to || q !== mq || r !== mr || lat != (sp ? 0 : int'(W))) begin
        $display("FAIL random[%0d] s=%b %h/%h q=%h r=%h lat=%0d, required q=%h r=%h lat=%0d",
                 i, s, a, b, q, r, lat, mq, mr, sp ? 0 : int'(W));
      end else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start;
    logic [W-1:0] q, r;
    int lat, bcnt;
    bit ov, to, ab;
    run_op(1'b0, 32'd1000, 32'd33, 5, q, r, lat, bcnt, ov, to, ab);
    total++;
    if (to || q !== 32'd30 || r !== 32'd10 || lat != int'(W)) begin
      $display("FAIL ignore_start q=%0d r=%0d lat=%0d, required q=30 r=10 lat=%0d",
               q, r, lat, W);
    end else pass_cnt++;
  endtask

  task automatic test_abort_reset;
    logic [W-1:0] q, r, mq, mr;
    int lat, bcnt;
    bit ov, to, ab, sp, saw_done;
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd99999; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({busy, done, quotient, remainder} !== '0) begin
      $display("FAIL abort_reset busy=%b done=%b q=%h r=%h, required all zero",
               busy, done, quotient, remainder);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    total++;
    if (saw_done) $display("FAIL abort_no_done activity seen after reset, required none");
    else pass_cnt++;
    ref_div(1'b1, 32'hFFFF_0000, 32'd12345, mq, mr, sp);
    run_op(1'b1, 32'hFFFF_0000, 32'd12345, 0, q, r, lat, bcnt, ov, to, ab);
    total++;
    if (to || q !== mq || r !== mr) begin
      $display("FAIL after_reset_op q=%h r=%h, required q=%h r=%h", q, r, mq, mr);
    end else pass_cnt++;
  endtask

  // start held high: accepts repeat at the earliest legal edge.
  task automatic test_back_to_back(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int exp_gap);
    int first, gap;
    first = -1; gap = -1;
    @(negedge clk);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = cyc;
        else begin
          gap = cyc - first;
          break;
        end
      end
    end
    start = 1'b0;
    repeat (int'(W) + 4) @(negedge clk);
    total++;
    if (gap != exp_gap) begin
      $display("FAIL back_to_back s=%b %h/%h gap=%0d, required %0d", s, a, b, gap, exp_gap);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_abort_reset();
    test_back_to_back(1'b0, 32'd500, 32'd9, int'(W) + 2);
    test_back_to_back(1'b0, 32'd500, 32'd0, 2);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
